// File: rtl/spi_ram_master_if.sv
// ============================================================================
// spi_ram_master_if : host command/reply handshake plus SPI pins of the master
// Revision: 1.0
// ============================================================================
`default_nettype none

interface spi_ram_master_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [FRAME_W-1:0] cmd_word;
    logic               busy;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_data;
    logic               SS_n;
    logic               MOSI;
    logic               MISO;

    modport master (
        input  cmd_valid, cmd_word, MISO,
        output cmd_ready, busy, rd_valid, rd_data, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_word, MISO,
        input  cmd_ready, busy, rd_valid, rd_data, SS_n, MOSI
    );
endinterface

`default_nettype wire

// File: rtl/spi_ram_master.sv
// ============================================================================
// spi_ram_master : serialises {cmd,payload} words onto MOSI, captures read replies
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_ram_master #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    spi_ram_master_if.master bus
);

    localparam int CNT_MAX = (FRAME_W > DATA_W)
                           ? ((FRAME_W > RD_LAT) ? FRAME_W : RD_LAT)
                           : ((DATA_W  > RD_LAT) ? DATA_W  : RD_LAT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEAD    = 3'd1,
        SHIFT   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state,    nxt_state;
    logic [FRAME_W-1:0] sreg,     nxt_sreg;
    logic [CNT_W-1:0]   cnt,      nxt_cnt;
    logic [DATA_W-1:0]  cap,      nxt_cap;
    logic [DATA_W-1:0]  rd_data,  nxt_rd_data;
    logic               ss_n,     nxt_ss_n;
    logic               mosi,     nxt_mosi;
    logic               rd_valid, nxt_rd_valid;
    logic               is_read,  nxt_is_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            cap      <= '0;
            rd_data  <= '0;
            ss_n     <= 1'b1;
            mosi     <= 1'b0;
            rd_valid <= 1'b0;
            is_read  <= 1'b0;
        end else begin
            state    <= nxt_state;
            sreg     <= nxt_sreg;
            cnt      <= nxt_cnt;
            cap      <= nxt_cap;
            rd_data  <= nxt_rd_data;
            ss_n     <= nxt_ss_n;
            mosi     <= nxt_mosi;
            rd_valid <= nxt_rd_valid;
            is_read  <= nxt_is_read;
        end
    end

    always_comb begin
        nxt_state    = state;
        nxt_sreg     = sreg;
        nxt_cnt      = cnt;
        nxt_cap      = cap;
        nxt_rd_data  = rd_data;
        nxt_ss_n     = ss_n;
        nxt_mosi     = mosi;
        nxt_rd_valid = 1'b0;
        nxt_is_read  = is_read;

        case (state)
            IDLE: begin
                // The lead bit repeats word[MSB]; the slave uses it to pick its write or read path.
                if (bus.cmd_valid) begin
                    nxt_state   = LEAD;
                    nxt_sreg    = bus.cmd_word;
                    nxt_is_read = (bus.cmd_word[FRAME_W-1 -: 2] == 2'b11);
                    nxt_ss_n    = 1'b0;
                    nxt_mosi    = bus.cmd_word[FRAME_W-1];
                    nxt_cnt     = '0;
                end
            end
            LEAD: begin
                nxt_state = SHIFT;
                nxt_mosi  = sreg[FRAME_W-1];
                nxt_sreg  = sreg << 1;
                nxt_cnt   = CNT_W'(1);
            end
            SHIFT: begin
                if (cnt == CNT_W'(FRAME_W)) begin
                    nxt_cnt  = '0;
                    nxt_mosi = 1'b0;
                    if (is_read) begin
                        nxt_state = WAIT;
                    end else begin
                        nxt_state = DONE;
                        nxt_ss_n  = 1'b1;
                    end
                end else begin
                    nxt_mosi = sreg[FRAME_W-1];
                    nxt_sreg = sreg << 1;
                    nxt_cnt  = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(RD_LAT - 1)) begin
                    nxt_state = CAPTURE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                nxt_cap = {cap[DATA_W-2:0], bus.MISO};
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    nxt_rd_data  = {cap[DATA_W-2:0], bus.MISO};
                    nxt_rd_valid = 1'b1;
                    nxt_ss_n     = 1'b1;
                    nxt_state    = DONE;
                    nxt_cnt      = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
                nxt_ss_n  = 1'b1;
                nxt_mosi  = 1'b0;
                nxt_cnt   = '0;
            end
        endcase
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_data;
    assign bus.SS_n      = ss_n;
    assign bus.MOSI      = mosi;

endmodule

`default_nettype wire
